// File: rtl/acc_sample_scheduler.sv
// ---------------------------------------------------------------------------
// acc_sample_scheduler
//
// Purpose:
//   Sequencer that sits between the ACL2 SPI wrapper and the gesture/BT
//   packetizer. Once the wrapper reports init complete, it fires a one-cycle
//   acc_start every SAMPLE_DIV clocks. When the wrapper reports a finished
//   read, it captures x/y/z and smooths each axis with a first-order IIR
//   filter:
//     filt += (raw - filt) >>> SHIFT
//   The filtered sample is then offered on a valid/ready port.
//
// Parameters:
//   SAMPLE_DIV  clocks per sample tick (>= 8)
//   TIMEOUT     max clocks spent waiting for a read before abort (>= 2)
//   SHIFT       IIR weight; 0 makes the filter a pass-through
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   enable          1 = schedule samples, 0 = no new starts
//   filter_rst      sync pulse; the next sample reloads the filter
//   acc_done_init   wrapper init complete (level)
//   acc_done_read   wrapper read complete (rising edge used)
//   acc_x/y/z       signed raw axes from the wrapper
//   acc_start       one-cycle start pulse to the wrapper
//   sample_x/y/z    signed filtered axes
//   sample_valid    filtered sample available, held until accepted
//   sample_ready    consumer accepts when valid & ready
//   busy            high in START / WAIT_READ / FILTER
//   overrun         pulse: unaccepted sample overwritten or tick dropped
//   timeout_err     pulse: read aborted on timeout
//   err_count       saturating count of timeouts
// ---------------------------------------------------------------------------
module acc_sample_scheduler #(
  parameter int SAMPLE_DIV = 1_000_000,
  parameter int TIMEOUT    = 65_535,
  parameter int SHIFT      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               filter_rst,
  input  logic               acc_done_init,
  input  logic               acc_done_read,
  input  logic signed [15:0] acc_x,
  input  logic signed [15:0] acc_y,
  input  logic signed [15:0] acc_z,
  output logic               acc_start,
  output logic signed [15:0] sample_x,
  output logic signed [15:0] sample_y,
  output logic signed [15:0] sample_z,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               busy,
  output logic               overrun,
  output logic               timeout_err,
  output logic [7:0]         err_count
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_READ = 3'd3;
  localparam logic [2:0] S_FILTER    = 3'd4;

  logic [2:0]        state;
  logic [TW-1:0]     tick_cnt;
  logic              tick_pending;
  logic [CW-1:0]     to_cnt;
  logic              done_prev;
  logic signed [15:0] raw_x, raw_y, raw_z;
  logic signed [15:0] filt_x, filt_y, filt_z;
  logic              primed;

  logic              cnt_run;
  logic              tick;
  logic              consume;
  logic              tick_drop;
  logic              read_edge;
  logic              read_timeout;
  logic              load;
  logic              reload;
  logic              accept;
  logic signed [15:0] new_x, new_y, new_z;

  // One IIR step. The difference is taken at 17 bits so the full
  // -32768..32767 span cannot wrap; the arithmetic shift floors toward
  // minus infinity. The result lies between filt and raw, so keeping only
  // the low 16 bits of the step is exact.
  function automatic logic signed [15:0] iir_step(
    input logic signed [15:0] filt,
    input logic signed [15:0] raw
  );
    logic signed [16:0] diff;
    logic signed [16:0] step;
    diff = {raw[15], raw} - {filt[15], filt};
    step = diff >>> SHIFT;
    return filt + step[15:0];
  endfunction

  // Decode of the per-cycle events that several blocks below react to.
  always_comb begin
    cnt_run      = enable && (state != S_WAIT_INIT);
    tick         = cnt_run && (tick_cnt == TICK_LAST);
    consume      = (state == S_IDLE) && tick_pending && enable;
    tick_drop    = tick && tick_pending && !consume;
    read_edge    = (state == S_WAIT_READ) && acc_done_read && !done_prev;
    read_timeout = (state == S_WAIT_READ) && !read_edge && (to_cnt == TO_LAST);
    load         = (state == S_FILTER);
    reload       = !primed || filter_rst;
    accept       = sample_valid && sample_ready;
  end

  // Next filter value per axis; an unprimed filter or a reload request
  // takes the raw sample directly.
  always_comb begin
    new_x = reload ? raw_x : iir_step(filt_x, raw_x);
    new_y = reload ? raw_y : iir_step(filt_y, raw_y);
    new_z = reload ? raw_z : iir_step(filt_z, raw_z);
  end

  // Sample-rate divider. It only runs once init is done and sampling is
  // enabled; a terminal count raises tick_pending. A tick that arrives while
  // one is still pending is dropped (and flagged as overrun below). If the
  // pending tick is consumed on the same cycle a new one arrives, the new
  // one stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt     <= '0;
      tick_pending <= 1'b0;
    end else begin
      if (!cnt_run || tick)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;

      if (!enable)
        tick_pending <= 1'b0;
      else if (tick)
        tick_pending <= 1'b1;
      else if (consume)
        tick_pending <= 1'b0;
    end
  end

  // Main sequencer. START clears the timeout counter and the done_read
  // history so that a level left high from the previous read cannot be
  // taken as a fresh edge. In WAIT_READ an edge on the last allowed cycle
  // still wins over the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT_INIT;
      to_cnt    <= '0;
      done_prev <= 1'b0;
      raw_x     <= '0;
      raw_y     <= '0;
      raw_z     <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_WAIT_INIT: begin
          if (acc_done_init)
            state <= S_IDLE;
        end
        S_IDLE: begin
          if (consume)
            state <= S_START;
        end
        S_START: begin
          to_cnt    <= '0;
          done_prev <= 1'b0;
          state     <= S_WAIT_READ;
        end
        S_WAIT_READ: begin
          done_prev <= acc_done_read;
          if (read_edge) begin
            raw_x <= acc_x;
            raw_y <= acc_y;
            raw_z <= acc_z;
            state <= S_FILTER;
          end else if (read_timeout) begin
            if (err_count != 8'hFF)
              err_count <= err_count + 8'd1;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_FILTER: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_WAIT_INIT;
        end
      endcase
    end
  end

  // Filter state. The filter registers double as the output data, which is
  // only rewritten in FILTER and therefore stays stable while valid is held.
  // A filter_rst seen outside FILTER is remembered by clearing primed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_x <= '0;
      filt_y <= '0;
      filt_z <= '0;
      primed <= 1'b0;
    end else if (load) begin
      filt_x <= new_x;
      filt_y <= new_y;
      filt_z <= new_z;
      primed <= 1'b1;
    end else if (filter_rst) begin
      primed <= 1'b0;
    end
  end

  // Output handshake. A new sample always leaves valid high, even when the
  // old one is accepted on the same cycle; only overwriting an unaccepted
  // sample (or dropping a tick) counts as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (load)
        sample_valid <= 1'b1;
      else if (accept)
        sample_valid <= 1'b0;

      overrun <= (load && sample_valid && !sample_ready) || tick_drop;
    end
  end

  // The timeout pulse marks the last WAIT_READ cycle itself, so it lines up
  // with the abort decision rather than trailing it by a clock.
  always_comb begin
    acc_start   = (state == S_START);
    busy        = (state == S_START) || (state == S_WAIT_READ) || (state == S_FILTER);
    timeout_err = read_timeout;
    sample_x    = filt_x;
    sample_y    = filt_y;
    sample_z    = filt_z;
  end

endmodule

// File: tb/tb_acc_sample_scheduler.sv
// ---------------------------------------------------------------------------
// tb_acc_sample_scheduler
//
// Directed bench for acc_sample_scheduler with SAMPLE_DIV=100, TIMEOUT=50,
// SHIFT=2. Inputs are driven 1 ns after each rising edge and outputs are
// sampled at the same point. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_acc_sample_scheduler;

  localparam int SAMPLE_DIV = 100;
  localparam int TIMEOUT    = 50;
  localparam int SHIFT      = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               filter_rst;
  logic               acc_done_init;
  logic               acc_done_read;
  logic signed [15:0] acc_x, acc_y, acc_z;
  logic               acc_start;
  logic signed [15:0] sample_x, sample_y, sample_z;
  logic               sample_valid;
  logic               sample_ready;
  logic               busy;
  logic               overrun;
  logic               timeout_err;
  logic [7:0]         err_count;

  int checks   = 0;
  int failures = 0;

  int cyc         = 0;
  int startCount  = 0;
  int widthErrors = 0;
  logic prevStart = 1'b0;

  // Expected x / y sequences for a 1000 / -1000 step decaying toward 0.
  int expX[4] = '{1000, 750, 562, 421};
  int expY[4] = '{-1000, -750, -563, -423};

  acc_sample_scheduler #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .TIMEOUT   (TIMEOUT),
    .SHIFT     (SHIFT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .filter_rst   (filter_rst),
    .acc_done_init(acc_done_init),
    .acc_done_read(acc_done_read),
    .acc_x        (acc_x),
    .acc_y        (acc_y),
    .acc_z        (acc_z),
    .acc_start    (acc_start),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .err_count    (err_count)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Free-running cycle index used to measure start-to-start spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Counts every start pulse and flags any pulse wider than one cycle.
  always @(posedge clk) begin
    #1;
    if (acc_start) begin
      startCount++;
      if (prevStart)
        widthErrors++;
    end
    prevStart = acc_start;
  end

  // Hard stop in case some wait is never satisfied.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Steps the clock until acc_start is seen or the budget runs out.
  task automatic waitForStart(input int budget, output bit found, output int startCyc,
                              output int steps);
    found    = 1'b0;
    startCyc = 0;
    steps    = 0;
    for (int i = 0; i < budget && !found; i++) begin
      stepClock();
      steps++;
      if (acc_start) begin
        found    = 1'b1;
        startCyc = cyc;
      end
    end
  endtask

  // Models the wrapper for one read, starting from the cycle acc_start is
  // seen: raise done_read after 'delay' clocks with the given axes, then
  // return on the cycle the filtered sample should first be visible.
  task automatic applyStimulus(input int delay, input int x, input int y, input int z,
                               input bit checkLatency);
    repeat (delay) stepClock();
    acc_x         = 16'(x);
    acc_y         = 16'(y);
    acc_z         = 16'(z);
    acc_done_read = 1'b1;
    stepClock();
    acc_done_read = 1'b0;
    if (checkLatency)
      checkOutput("valid_at_edge_plus_1", int'(sample_valid), 0);
    stepClock();
    if (checkLatency)
      checkOutput("valid_at_edge_plus_2", int'(sample_valid), 1);
  endtask

  initial begin
    bit found;
    int sc;
    int prevSc;
    int steps;
    int s0;
    int n;

    rst           = 1'b1;
    enable        = 1'b1;
    filter_rst    = 1'b0;
    acc_done_init = 1'b0;
    acc_done_read = 1'b0;
    acc_x         = '0;
    acc_y         = '0;
    acc_z         = '0;
    sample_ready  = 1'b1;

    repeat (3) stepClock();
    checkOutput("reset_acc_start", int'(acc_start), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(sample_valid), 0);
    checkOutput("reset_err_count", int'(err_count), 0);
    checkOutput("reset_sample_x", int'(sample_x), 0);
    rst = 1'b0;

    // No starts while init is not done.
    s0 = startCount;
    repeat (1000) stepClock();
    checkOutput("no_start_before_init", startCount - s0, 0);
    checkOutput("busy_before_init", int'(busy), 0);

    // Init raised: first start after 1 cycle to IDLE + 100 count + 1 to START.
    acc_done_init = 1'b1;
    waitForStart(150, found, sc, steps);
    checkOutput("init_start_seen", int'(found), 1);
    checkOutput("init_to_start_clocks", steps, 102);
    prevSc = sc;

    // First read exercises the done_read -> valid latency.
    applyStimulus(20, expX[0], expY[0], 5, 1'b1);
    checkOutput("x_0", int'(sample_x), expX[0]);
    checkOutput("y_0", int'(sample_y), expY[0]);
    checkOutput("z_0", int'(sample_z), 5);

    // Step response of the IIR on x and y; starts every SAMPLE_DIV clocks.
    for (int i = 1; i < 4; i++) begin
      waitForStart(200, found, sc, steps);
      checkOutput("step_start_seen", int'(found), 1);
      checkOutput("step_start_period", sc - prevSc, 100);
      prevSc = sc;
      applyStimulus(20, 0, 0, 5, 1'b0);
      checkOutput("x_step", int'(sample_x), expX[i]);
      checkOutput("y_step", int'(sample_y), expY[i]);
      checkOutput("z_step", int'(sample_z), 5);
    end

    // Filter reload, then the full-scale jump from -32768 to 32767.
    filter_rst = 1'b1;
    stepClock();
    filter_rst = 1'b0;
    waitForStart(200, found, sc, steps);
    checkOutput("reload_start_period", sc - prevSc, 100);
    prevSc = sc;
    applyStimulus(20, -32768, 0, 0, 1'b0);
    checkOutput("x_reload_min", int'(sample_x), -32768);
    waitForStart(200, found, sc, steps);
    prevSc = sc;
    applyStimulus(20, 32767, 0, 0, 1'b0);
    checkOutput("x_full_scale_step", int'(sample_x), -16385);

    // Read that never completes: timeout on the 50th clock after start.
    waitForStart(200, found, sc, steps);
    checkOutput("timeout_start_period", sc - prevSc, 100);
    prevSc = sc;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      stepClock();
      n++;
      if (timeout_err)
        break;
    end
    checkOutput("timeout_delay", n, 50);
    stepClock();
    checkOutput("timeout_pulse_width", int'(timeout_err), 0);
    checkOutput("err_count_after_timeout", int'(err_count), 1);
    checkOutput("busy_after_timeout", int'(busy), 0);

    // Two samples with the consumer stalled: overrun, second data kept.
    filter_rst   = 1'b1;
    stepClock();
    filter_rst   = 1'b0;
    sample_ready = 1'b0;
    waitForStart(200, found, sc, steps);
    checkOutput("after_timeout_start_period", sc - prevSc, 100);
    prevSc = sc;
    applyStimulus(20, 100, 0, 0, 1'b0);
    checkOutput("stall_x_first", int'(sample_x), 100);
    checkOutput("stall_no_overrun_first", int'(overrun), 0);
    waitForStart(200, found, sc, steps);
    prevSc = sc;
    applyStimulus(20, 200, 0, 0, 1'b0);
    checkOutput("stall_overrun", int'(overrun), 1);
    checkOutput("stall_x_second", int'(sample_x), 125);
    checkOutput("stall_valid", int'(sample_valid), 1);
    stepClock();
    checkOutput("overrun_pulse_width", int'(overrun), 0);
    checkOutput("valid_held", int'(sample_valid), 1);
    sample_ready = 1'b1;
    stepClock();
    checkOutput("valid_drop_after_accept", int'(sample_valid), 0);

    // Asynchronous reset in the middle of a read.
    waitForStart(200, found, sc, steps);
    checkOutput("pre_reset_start_seen", int'(found), 1);
    repeat (5) stepClock();
    checkOutput("busy_in_read", int'(busy), 1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_acc_start", int'(acc_start), 0);
    checkOutput("async_reset_err_count", int'(err_count), 0);
    checkOutput("async_reset_sample_x", int'(sample_x), 0);
    acc_done_init = 1'b0;
    repeat (2) stepClock();
    rst = 1'b0;
    s0 = startCount;
    repeat (300) stepClock();
    checkOutput("no_start_after_reset", startCount - s0, 0);
    acc_done_init = 1'b1;
    waitForStart(150, found, sc, steps);
    checkOutput("reinit_start_seen", int'(found), 1);
    checkOutput("reinit_to_start_clocks", steps, 102);

    checkOutput("start_pulse_width", widthErrors, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
